axi_lite_rr_arbiter: RTL

- Parametrised N-master to 1-slave AXI4-Lite arbiter with round-robin fairness.
- Sits between the core's fetch, load/store and any future DMA or debug masters and the single memory slave (sram).
- Carries one outstanding transaction at a time.
- Generalises the fixed two-master arbiter:
  - N masters.
  - Configurable address and data widths.
  - Full wstrb/resp routing.
  - AW and W may be accepted in either order.

---
 rtl/axi_arb_pkg.sv | 16 +
 rtl/axi_lite_rr_arbiter_rr_pick.sv | 30 +++
 rtl/axi_lite_rr_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared state encoding and AXI response codes for the round-robin AXI4-Lite arbiter
package axi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_D,
        WR_AW,
        WR_B
    } arb_state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, searches from ptr+1 upward and wraps back to ptr itself
module rr_pick #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int k = 1; k <= N; k++) begin
            j = IW'((int'(ptr) + k) % N);
            if (!any && req[j]) begin
                any = 1'b1;
                idx = j;
            end
        end
        gnt[idx] = any;
    end

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// axi_lite_rr_arbiter: N-master to 1-slave AXI4-Lite arbiter, round-robin, one outstanding transaction
module axi_lite_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter  int N_MST  = 2,
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8,
    localparam int IW     = $clog2(N_MST)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_MST-1:0]           m_arvalid,
    output logic [N_MST-1:0]           m_arready,
    input  logic [N_MST*ADDR_W-1:0]    m_araddr,
    output logic [N_MST-1:0]           m_rvalid,
    input  logic [N_MST-1:0]           m_rready,
    output logic [DATA_W-1:0]          m_rdata,
    output logic [1:0]                 m_rresp,
    input  logic [N_MST-1:0]           m_awvalid,
    output logic [N_MST-1:0]           m_awready,
    input  logic [N_MST*ADDR_W-1:0]    m_awaddr,
    input  logic [N_MST-1:0]           m_wvalid,
    output logic [N_MST-1:0]           m_wready,
    input  logic [N_MST*DATA_W-1:0]    m_wdata,
    input  logic [N_MST*STRB_W-1:0]    m_wstrb,
    output logic [N_MST-1:0]           m_bvalid,
    input  logic [N_MST-1:0]           m_bready,
    output logic [1:0]                 m_bresp,
    output logic                       s_arvalid,
    input  logic                       s_arready,
    output logic [ADDR_W-1:0]          s_araddr,
    input  logic                       s_rvalid,
    output logic                       s_rready,
    input  logic [DATA_W-1:0]          s_rdata,
    input  logic [1:0]                 s_rresp,
    output logic                       s_awvalid,
    input  logic                       s_awready,
    output logic [ADDR_W-1:0]          s_awaddr,
    output logic                       s_wvalid,
    input  logic                       s_wready,
    output logic [DATA_W-1:0]          s_wdata,
    output logic [STRB_W-1:0]          s_wstrb,
    input  logic                       s_bvalid,
    output logic                       s_bready,
    input  logic [1:0]                 s_bresp,
    output logic [N_MST-1:0]           grant,
    output logic                       busy
);

    arb_state_e       state_q, state_d;
    logic [N_MST-1:0] grant_q, grant_d;
    logic [IW-1:0]    gidx_q, gidx_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;

    logic [N_MST-1:0] req, pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic             ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign req   = m_arvalid | m_awvalid;
    assign ar_hs = s_arvalid & s_arready;
    assign r_hs  = s_rvalid & s_rready;
    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid & s_wready;
    assign b_hs  = s_bvalid & s_bready;

    rr_pick #(.N(N_MST)) u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= IW'(N_MST - 1);
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: if (pick_any) begin
                grant_d = pick_gnt;
                gidx_d  = pick_idx;
                ptr_d   = pick_idx;
                state_d = m_arvalid[pick_idx] ? RD_A : WR_AW;
            end
            RD_A: if (ar_hs) state_d = RD_D;
            RD_D: if (r_hs) begin
                state_d = IDLE;
                grant_d = '0;
            end
            WR_AW: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) state_d = WR_B;
            end
            WR_B: if (b_hs) begin
                state_d   = IDLE;
                grant_d   = '0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // readys go back only to the owner, masked by grant_q
    always_comb begin
        s_arvalid = (state_q == RD_A) && m_arvalid[gidx_q];
        m_arready = (state_q == RD_A && s_arready) ? grant_q : '0;
        s_araddr  = m_araddr[gidx_q*ADDR_W +: ADDR_W];
        s_rready  = (state_q == RD_D) && m_rready[gidx_q];
        m_rvalid  = (state_q == RD_D && s_rvalid) ? grant_q : '0;
        m_rdata   = s_rdata;
        m_rresp   = s_rresp;
        s_awvalid = (state_q == WR_AW) && !aw_done_q && m_awvalid[gidx_q];
        m_awready = (state_q == WR_AW && !aw_done_q && s_awready) ? grant_q : '0;
        s_awaddr  = m_awaddr[gidx_q*ADDR_W +: ADDR_W];
        s_wvalid  = (state_q == WR_AW) && !w_done_q && m_wvalid[gidx_q];
        m_wready  = (state_q == WR_AW && !w_done_q && s_wready) ? grant_q : '0;
        s_wdata   = m_wdata[gidx_q*DATA_W +: DATA_W];
        s_wstrb   = m_wstrb[gidx_q*STRB_W +: STRB_W];
        s_bready  = (state_q == WR_B) && m_bready[gidx_q];
        m_bvalid  = (state_q == WR_B && s_bvalid) ? grant_q : '0;
        m_bresp   = s_bresp;
        grant     = grant_q;
        busy      = state_q != IDLE;
    end

endmodule
